// File: rtl/syndrome_round_feeder_pkg.sv
// +----------------------------------------------------------------------------+
// | helios_feeder_pkg : shared types and sizing helpers for the round feeder   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package helios_feeder_pkg;
    localparam int WORD_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } feeder_state_t;

    function automatic int words_per_frame(input int pu_count);
        return (pu_count + WORD_WIDTH - 1) / WORD_WIDTH;
    endfunction
endpackage

`default_nettype wire

// File: rtl/syndrome_round_feeder_if.sv
// +----------------------------------------------------------------------------+
// | syndrome_round_feeder_if : valid/ready word stream into the feeder         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface syndrome_round_feeder_if;
    import helios_feeder_pkg::*;

    logic [WORD_WIDTH-1:0] s_data;
    logic                  s_valid;
    logic                  s_ready;

    modport master (output s_data, output s_valid, input s_ready);
    modport slave  (input s_data, input s_valid, output s_ready);
endinterface

`default_nettype wire

// File: rtl/syndrome_round_feeder_packer.sv
// +----------------------------------------------------------------------------+
// | syndrome_word_packer : packs stream words into the shadow frame buffer     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module syndrome_word_packer
    import helios_feeder_pkg::*;
#(
    parameter int PU_COUNT = 100
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    syndrome_round_feeder_if.slave s_if,
    input  wire logic              consume,
    output logic [PU_COUNT-1:0]    shadow,
    output logic                   shadow_full
);
    localparam int WORDS     = words_per_frame(PU_COUNT);
    localparam int LAST_BITS = PU_COUNT - WORD_WIDTH * (WORDS - 1);
    localparam int IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    logic [IDX_W-1:0]    word_idx;
    logic [PU_COUNT-1:0] shadow_d;
    logic                accept;

    assign s_if.s_ready = !shadow_full;
    assign accept       = s_if.s_valid && !shadow_full;

    // The final word is truncated so padding bits never reach the decoder.
    always_comb begin
        shadow_d = shadow;
        for (int w = 0; w < WORDS - 1; w++) begin
            if (accept && word_idx == IDX_W'(w))
                shadow_d[w*WORD_WIDTH +: WORD_WIDTH] = s_if.s_data;
        end
        if (accept && word_idx == LAST_IDX)
            shadow_d[PU_COUNT-1 -: LAST_BITS] = s_if.s_data[LAST_BITS-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            word_idx    <= '0;
            shadow_full <= 1'b0;
            shadow      <= '0;
        end else begin
            shadow <= shadow_d;
            if (consume) begin
                shadow_full <= 1'b0;
            end else if (accept) begin
                if (word_idx == LAST_IDX) begin
                    shadow_full <= 1'b1;
                    word_idx    <= '0;
                end else begin
                    word_idx <= word_idx + 1'b1;
                end
            end
        end
    end
endmodule

`default_nettype wire

// File: rtl/syndrome_round_feeder.sv
// +----------------------------------------------------------------------------+
// | syndrome_round_feeder : launches packed syndrome frames into the decoder   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module syndrome_round_feeder
    import helios_feeder_pkg::*;
#(
    parameter int CODE_DISTANCE_X    = 15,
    parameter int CODE_DISTANCE_Z    = 14,
    parameter int MEASUREMENT_ROUNDS = (CODE_DISTANCE_X > CODE_DISTANCE_Z) ? CODE_DISTANCE_X : CODE_DISTANCE_Z,
    parameter int PU_COUNT           = CODE_DISTANCE_X * CODE_DISTANCE_Z * MEASUREMENT_ROUNDS,
    parameter int TIMEOUT_CYCLES     = 0
) (
    input  wire logic              clk,
    input  wire logic              reset_n,
    syndrome_round_feeder_if.slave s_if,
    output logic [PU_COUNT-1:0]    measurements,
    output logic                   new_round_start,
    input  wire logic              result_valid,
    output logic                   busy,
    output logic [31:0]            frames_done,
    output logic                   timeout_err
);
    localparam logic [31:0] TIMEOUT_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    feeder_state_t       state, state_d;
    logic [PU_COUNT-1:0] shadow;
    logic                shadow_full;
    logic                rv_q, rv_rise;
    logic                launch, complete, expire;
    logic [31:0]         busy_cnt;

    syndrome_word_packer #(.PU_COUNT(PU_COUNT)) u_packer (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_if        (s_if),
        .consume     (launch),
        .shadow      (shadow),
        .shadow_full (shadow_full)
    );

    // Only a fresh rise completes a frame; a level left high from before launch does not.
    assign rv_rise = result_valid && !rv_q;

    always_comb begin
        state_d  = state;
        launch   = 1'b0;
        complete = 1'b0;
        expire   = 1'b0;
        case (state)
            IDLE: begin
                if (shadow_full) begin
                    launch  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (rv_rise) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end else if (TIMEOUT_CYCLES != 0 && busy_cnt == TIMEOUT_LAST) begin
                    expire  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rv_q            <= 1'b0;
            measurements    <= '0;
            new_round_start <= 1'b0;
            busy            <= 1'b0;
            busy_cnt        <= '0;
            frames_done     <= '0;
            timeout_err     <= 1'b0;
        end else begin
            rv_q            <= result_valid;
            new_round_start <= launch;
            busy            <= (state_d == BUSY);
            if (launch) begin
                measurements <= shadow;
                busy_cnt     <= '0;
            end else if (state == BUSY) begin
                busy_cnt <= busy_cnt + 32'd1;
            end
            if (complete) frames_done <= frames_done + 32'd1;
            if (expire)   timeout_err <= 1'b1;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_syndrome_round_feeder.sv
// +----------------------------------------------------------------------------+
// | tb_syndrome_round_feeder : directed self-checking bench for the feeder     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_syndrome_round_feeder;
    localparam int PU = 100;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          result_valid = 1'b0;
    logic [PU-1:0] measurements;
    logic          new_round_start, busy, timeout_err;
    logic [31:0]   frames_done;
    int            compared = 0;
    int            mismatched = 0;

    localparam logic [PU-1:0] F1 = {4'hF, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [PU-1:0] F2 = {4'hA, 32'hCCCCCCCC, 32'hBBBBBBBB, 32'hAAAAAAAA};
    localparam logic [PU-1:0] F3 = {4'h5, 32'hDEADBEEF, 32'h89ABCDEF, 32'h01234567};

    syndrome_round_feeder_if s_if ();

    syndrome_round_feeder #(
        .CODE_DISTANCE_X (5),
        .CODE_DISTANCE_Z (4),
        .TIMEOUT_CYCLES  (20)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .s_if            (s_if.slave),
        .measurements    (measurements),
        .new_round_start (new_round_start),
        .result_valid    (result_valid),
        .busy            (busy),
        .frames_done     (frames_done),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one word and returns 1 time unit after the edge that accepted it.
    task automatic send_word(input logic [31:0] d);
        bit done = 0;
        s_if.s_data  = d;
        s_if.s_valid = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            if (s_if.s_ready) done = 1;
            step();
        end
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_meas"}, measurements, 0);
        chk({tag, "_nrs"}, new_round_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frames"}, frames_done, 0);
        chk({tag, "_tmo"}, timeout_err, 0);
        chk({tag, "_ready"}, s_if.s_ready, 1);
    endtask

    initial begin
        s_if.s_data  = '0;
        s_if.s_valid = 1'b0;
        #12;
        chk_reset_vals("rst");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk_reset_vals("post_rst");

        // Frame 1 with result_valid already high: stale level must not complete it.
        result_valid = 1'b1;
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'hFFFFFFFF);
        s_if.s_valid = 1'b0;
        chk("t1_full_ready", s_if.s_ready, 0);
        chk("t1_nrs_early", new_round_start, 0);
        step();
        chk("t1_nrs", new_round_start, 1);
        chk("t1_busy", busy, 1);
        chk("t1_meas", measurements, F1);
        chk("t1_ready_after", s_if.s_ready, 1);

        // Frame 2 streams into the shadow while frame 1 decodes.
        send_word(32'hAAAAAAAA);
        chk("t1_nrs_once", new_round_start, 0);
        send_word(32'hBBBBBBBB);
        send_word(32'hCCCCCCCC);
        send_word(32'h0000000A);
        s_if.s_valid = 1'b0;
        chk("t3_ready_low", s_if.s_ready, 0);
        chk("t3_meas_hold", measurements, F1);
        chk("t2_stale_busy", busy, 1);
        chk("t2_stale_frames", frames_done, 0);
        result_valid = 1'b0;
        step();
        chk("t2_drop_busy", busy, 1);
        result_valid = 1'b1;
        step();
        chk("t2_done_busy", busy, 0);
        chk("t2_done_frames", frames_done, 1);
        chk("t3_meas_still", measurements, F1);
        step();
        chk("t3_launch_nrs", new_round_start, 1);
        chk("t3_launch_meas", measurements, F2);
        chk("t3_launch_busy", busy, 1);

        // Final word of frame 3 lands on the same edge as the result rise.
        result_valid = 1'b0;
        send_word(32'h01234567);
        send_word(32'h89ABCDEF);
        send_word(32'hDEADBEEF);
        result_valid = 1'b1;
        send_word(32'h00000005);
        s_if.s_valid = 1'b0;
        chk("t4_busy", busy, 0);
        chk("t4_frames", frames_done, 2);
        chk("t4_ready", s_if.s_ready, 0);
        chk("t4_nrs_pre", new_round_start, 0);
        step();
        chk("t4_nrs", new_round_start, 1);
        chk("t4_meas", measurements, F3);
        chk("t4_busy2", busy, 1);
        step();
        chk("t4_nrs_once", new_round_start, 0);
        chk("t4_frames_once", frames_done, 2);

        // Watchdog: launch was one edge ago, it fires on the 20th edge after launch.
        for (int i = 0; i < 18; i++) step();
        chk("t5_not_yet_tmo", timeout_err, 0);
        chk("t5_not_yet_busy", busy, 1);
        step();
        chk("t5_tmo", timeout_err, 1);
        chk("t5_busy", busy, 0);
        chk("t5_frames", frames_done, 2);
        result_valid = 1'b0;
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        send_word(32'hFFFFFFFF);
        s_if.s_valid = 1'b0;
        step();
        chk("t5_relaunch_nrs", new_round_start, 1);
        chk("t5_relaunch_meas", measurements, F1);
        chk("t5_tmo_sticky", timeout_err, 1);

        // Asynchronous reset in the middle of a partial frame.
        send_word(32'h55555555);
        send_word(32'h66666666);
        s_if.s_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("t6_async");
        @(negedge clk);
        reset_n = 1'b1;
        step();
        send_word(32'h01234567);
        send_word(32'h89ABCDEF);
        send_word(32'hDEADBEEF);
        send_word(32'h00000005);
        s_if.s_valid = 1'b0;
        step();
        chk("t6_nrs", new_round_start, 1);
        chk("t6_meas", measurements, F3);
        chk("t6_frames", frames_done, 0);
        chk("t6_tmo", timeout_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

`default_nettype wire
